// File: rtl/key_debouncer.sv
// Debounces four active-low push buttons into a registered, active-high key pattern.
// Optional macro KEY_MULTI_REJECT_EN: patterns with more than one key down are ignored.
module key_debouncer #(
   parameter int CLOCK_FREQ      = 50000000,
   parameter int DEBOUNCE_MS     = 20,
   parameter int DEBOUNCE_CYCLES = (CLOCK_FREQ / 1000) * DEBOUNCE_MS
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] keyRaw,
   output logic [3:0] key,
   output logic       keyValid,
   output logic       pressStrobe
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE             = 2'd0,
      PRESS_DEBOUNCE   = 2'd1,
      HELD             = 2'd2,
      RELEASE_DEBOUNCE = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [3:0]    candidate;
   logic [3:0]    sync_q1;
   logic [3:0]    sync_q2;
   logic [3:0]    key_sync;
   logic          wait_zero;

   function automatic logic accept(input logic [3:0] v);
`ifdef KEY_MULTI_REJECT_EN
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
`else
      return v != 4'd0;
`endif
   endfunction

   // Synchronizer resets to all-ones so the buttons read as released.
   // NOTE: sequential state always uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q1 <= 4'hF;
         sync_q2 <= 4'hF;
      end else begin
         sync_q1 <= keyRaw;
         sync_q2 <= sync_q1;
      end
   end

   assign key_sync = ~sync_q2;

   // wait_zero blocks the just-released pattern from retriggering until the keys read all-up.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         candidate   <= 4'd0;
         wait_zero   <= 1'b0;
         key         <= 4'd0;
         keyValid    <= 1'b0;
         pressStrobe <= 1'b0;
      end else begin
         pressStrobe <= 1'b0;
         case (state)
            IDLE: begin
               key      <= 4'd0;
               keyValid <= 1'b0;
               count    <= '0;
               if (key_sync == 4'd0)
                  wait_zero <= 1'b0;
               if (accept(key_sync) && !(wait_zero && key_sync == candidate)) begin
                  candidate <= key_sync;
                  wait_zero <= 1'b0;
                  state     <= PRESS_DEBOUNCE;
               end
            end
            PRESS_DEBOUNCE: begin
               if (key_sync != candidate) begin
                  count <= '0;
                  state <= IDLE;
               end else if (count == CNT_LAST) begin
                  key         <= candidate;
                  keyValid    <= 1'b1;
                  pressStrobe <= 1'b1;
                  count       <= '0;
                  state       <= HELD;
               end else begin
                  count <= count + 1'b1;
               end
            end
            HELD: begin
               if (key_sync != candidate) begin
                  count <= '0;
                  state <= RELEASE_DEBOUNCE;
               end
            end
            RELEASE_DEBOUNCE: begin
               if (key_sync == candidate) begin
                  count <= '0;
                  state <= HELD;
               end else if (count == CNT_LAST) begin
                  key       <= 4'd0;
                  keyValid  <= 1'b0;
                  wait_zero <= 1'b1;
                  count     <= '0;
                  state     <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               key      <= 4'd0;
               keyValid <= 1'b0;
               count    <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES = 8; edge numbering starts at the
// first rising edge that samples a new keyRaw value (edge 1), so confirmation lands on edge 11.
module tb_key_debouncer;

   logic       clock;
   logic       reset;
   logic [3:0] keyRaw;
   logic [3:0] key;
   logic       keyValid;
   logic       pressStrobe;

   int errors;
   int checks;

   key_debouncer #(
      .CLOCK_FREQ     (50000000),
      .DEBOUNCE_MS    (20),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .keyRaw     (keyRaw),
      .key        (key),
      .keyValid   (keyValid),
      .pressStrobe(pressStrobe)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      keyRaw = 4'hF;
      #12;
      checks++;
      if (key !== 4'd0) begin
         errors++;
         $display("FAIL reset_key: got %b expected %b", key, 4'd0);
      end
      checks++;
      if (keyValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b expected 0", keyValid);
      end
      checks++;
      if (pressStrobe !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobe: got %b expected 0", pressStrobe);
      end
      tick();
      reset = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_clean_press();
      logic [3:0] exp_key;
      keyRaw = 4'b1110;
      for (int n = 1; n <= 12; n++) begin
         tick();
         exp_key = (n >= 11) ? 4'b0001 : 4'b0000;
         checks++;
         if (key !== exp_key || keyValid !== (exp_key != 4'd0)) begin
            errors++;
            $display("FAIL press_key edge %0d: got key=%b valid=%b expected key=%b", n, key, keyValid, exp_key);
         end
         checks++;
         if (pressStrobe !== (n == 11)) begin
            errors++;
            $display("FAIL press_strobe edge %0d: got %b expected %b", n, pressStrobe, (n == 11));
         end
      end
      keyRaw = 4'b1111;
      for (int n = 1; n <= 12; n++) begin
         tick();
         exp_key = (n >= 11) ? 4'b0000 : 4'b0001;
         checks++;
         if (key !== exp_key || keyValid !== (exp_key != 4'd0) || pressStrobe !== 1'b0) begin
            errors++;
            $display("FAIL release_key edge %0d: got key=%b valid=%b strobe=%b expected key=%b strobe=0",
                     n, key, keyValid, pressStrobe, exp_key);
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_glitch();
      keyRaw = 4'b1101;
      repeat (5) tick();
      keyRaw = 4'b1111;
      for (int n = 1; n <= 20; n++) begin
         if (n > 1) tick();
         checks++;
         if (key !== 4'd0 || keyValid !== 1'b0 || pressStrobe !== 1'b0) begin
            errors++;
            $display("FAIL glitch step %0d: got key=%b valid=%b strobe=%b expected all zero",
                     n, key, keyValid, pressStrobe);
         end
      end
   endtask

   task automatic test_release_bounce();
      logic [3:0] exp_key;
      keyRaw = 4'b1011;
      for (int n = 1; n <= 11; n++) tick();
      checks++;
      if (key !== 4'b0100 || pressStrobe !== 1'b1) begin
         errors++;
         $display("FAIL bounce_confirm: got key=%b strobe=%b expected key=0100 strobe=1", key, pressStrobe);
      end
      repeat (3) tick();
      for (int phase = 0; phase < 4; phase++) begin
         keyRaw = (phase % 2 == 0) ? 4'b1111 : 4'b1011;
         for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (key !== 4'b0100 || pressStrobe !== 1'b0) begin
               errors++;
               $display("FAIL bounce_hold phase %0d cycle %0d: got key=%b strobe=%b expected key=0100 strobe=0",
                        phase, c, key, pressStrobe);
            end
         end
      end
      keyRaw = 4'b1111;
      for (int n = 1; n <= 12; n++) begin
         tick();
         exp_key = (n >= 11) ? 4'b0000 : 4'b0100;
         checks++;
         if (key !== exp_key || pressStrobe !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release edge %0d: got key=%b strobe=%b expected key=%b strobe=0",
                     n, key, pressStrobe, exp_key);
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_multi_key();
      logic [3:0] exp_key;
      keyRaw = 4'b1100;
      for (int n = 1; n <= 12; n++) begin
         tick();
`ifdef KEY_MULTI_REJECT_EN
         exp_key = 4'b0000;
         checks++;
         if (key !== exp_key || pressStrobe !== 1'b0) begin
            errors++;
            $display("FAIL multi_key edge %0d: got key=%b strobe=%b expected key=%b strobe=0",
                     n, key, pressStrobe, exp_key);
         end
`else
         exp_key = (n >= 11) ? 4'b0011 : 4'b0000;
         checks++;
         if (key !== exp_key || pressStrobe !== (n == 11)) begin
            errors++;
            $display("FAIL multi_key edge %0d: got key=%b strobe=%b expected key=%b strobe=%b",
                     n, key, pressStrobe, exp_key, (n == 11));
         end
`endif
      end
      keyRaw = 4'b1111;
      repeat (12) tick();
      checks++;
      if (key !== 4'd0 || keyValid !== 1'b0) begin
         errors++;
         $display("FAIL multi_release: got key=%b valid=%b expected key=0000 valid=0", key, keyValid);
      end
      repeat (3) tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_key;
      keyRaw = 4'b1110;
      repeat (11) tick();
      checks++;
      if (key !== 4'b0001) begin
         errors++;
         $display("FAIL b2b_first: got key=%b expected 0001", key);
      end
      keyRaw = 4'b1101;
      for (int n = 1; n <= 21; n++) begin
         tick();
         if (n < 11)      exp_key = 4'b0001;
         else if (n < 20) exp_key = 4'b0000;
         else             exp_key = 4'b0010;
         checks++;
         if (key !== exp_key || pressStrobe !== (n == 20)) begin
            errors++;
            $display("FAIL b2b_second edge %0d: got key=%b strobe=%b expected key=%b strobe=%b",
                     n, key, pressStrobe, exp_key, (n == 20));
         end
      end
      keyRaw = 4'b1111;
      repeat (12) tick();
      checks++;
      if (key !== 4'd0) begin
         errors++;
         $display("FAIL b2b_release: got key=%b expected 0000", key);
      end
      repeat (3) tick();
   endtask

   task automatic test_reset_mid_hold();
      logic [3:0] exp_key;
      keyRaw = 4'b0111;
      repeat (11) tick();
      checks++;
      if (key !== 4'b1000 || keyValid !== 1'b1) begin
         errors++;
         $display("FAIL hold_before_reset: got key=%b valid=%b expected key=1000 valid=1", key, keyValid);
      end
      repeat (2) tick();
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (key !== 4'd0 || keyValid !== 1'b0 || pressStrobe !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got key=%b valid=%b strobe=%b expected all zero", key, keyValid, pressStrobe);
      end
      repeat (2) tick();
      reset = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         tick();
         exp_key = (n >= 11) ? 4'b1000 : 4'b0000;
         checks++;
         if (key !== exp_key || pressStrobe !== (n == 11)) begin
            errors++;
            $display("FAIL after_reset edge %0d: got key=%b strobe=%b expected key=%b strobe=%b",
                     n, key, pressStrobe, exp_key, (n == 11));
         end
      end
      keyRaw = 4'b1111;
      repeat (12) tick();
      checks++;
      if (key !== 4'd0) begin
         errors++;
         $display("FAIL after_reset_release: got key=%b expected 0000", key);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_clean_press();
      test_glitch();
      test_release_bounce();
      test_multi_key();
      test_back_to_back();
      test_reset_mid_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
